mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory stage directly downstream of the CPU execute path; consumes `alu_result` as the effective address.
- Performs byte/half/word loads and stores over a req/ack data-memory bus.
- Produces a registered write-back record for the register file and stalls the pipeline while a bus transaction is outstanding.
- Also passes non-memory ALU results through to write-back with one cycle of latency.

Parameters:
- TIMEOUT, 15, max cycles `dmem_req` may stay high without `dmem_ack` before aborting (1..255).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute-stage record valid this cycle.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store (ex_mem_read and ex_mem_write never both 1).
- ex_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- ex_unsigned  in  1  zero-extend loads (else sign-extend).
- alu_result  in  32  effective address, or ALU result for non-memory ops.
- ex_store_data  in  32  store data, right-aligned.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  destination write enable.
- stall  out  1  unit busy; upstream holds its record.
- dmem_req  out  1  bus request, held until ack or timeout.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables, little-endian.
- dmem_ack  in  1  completion, valid only while dmem_req=1.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- wb_valid  out  1  one-cycle write-back/retire pulse.
- wb_reg_write  out  1  register-file write enable.
- wb_rd  out  5  destination register.
- wb_data  out  32  result.
- misalign_exc  out  1  one-cycle pulse.
- timeout_exc  out  1  one-cycle pulse.

Behaviour:
- Reset (RST=0, async): state IDLE.
  - All outputs 0: stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_*, exc pulses.
  - Timeout counter 0.
  - Reset mid-transaction drops dmem_req immediately; the transaction is abandoned and any later ack is ignored.
- States: IDLE, BUS, RESP.
- stall = (state != IDLE), registered-state decode. Upstream presents a new record only when stall=0.
- IDLE, ex_valid=0:
  - wb_valid=0 next cycle.
- IDLE, ex_valid=1, non-memory op:
  - Next cycle: wb_valid=1, wb_data=alu_result, wb_rd=ex_rd, wb_reg_write=ex_reg_write.
  - State stays IDLE. Latency 1.
- IDLE, memory op, misaligned (half with addr[0]=1; word with addr[1:0]!=0):
  - No bus access.
  - Next cycle: misalign_exc=1, wb_valid=1, wb_reg_write=0.
  - State stays IDLE.
- IDLE, memory op, aligned:
  - Capture addr low bits, size, unsigned, rd, reg_write into a request register.
  - Drive dmem_req=1, dmem_we, dmem_addr, dmem_be, dmem_wdata from the next cycle.
  - Go to BUS.
- Byte enables and write data:
  - byte: be = 1<<addr[1:0]; wdata = {4{data[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - word: be = 1111; wdata = data.
- BUS:
  - Counter increments each cycle without ack.
  - On dmem_ack=1: dmem_req drops next edge; capture dmem_rdata; go to RESP.
  - Counter reaching TIMEOUT without ack: drop dmem_req, pulse timeout_exc, wb_valid=1 with wb_reg_write=0, go to IDLE.
  - Ack arriving in the same cycle the counter hits TIMEOUT: ack wins.
  - dmem_* outputs are stable throughout BUS.
- RESP (one cycle): wb_valid=1, wb_rd=captured rd, then IDLE.
  - Load: select the lane by captured addr[1:0], sign/zero-extend to 32 bits, wb_reg_write = captured reg_write.
  - Store: wb_data=0, wb_reg_write=0.
  - stall stays high during RESP.
  - Best-case load latency: accept cycle N, req at N+1, ack at N+1, wb_valid at N+3.
- dmem_ack while dmem_req=0 is ignored.
- wb_valid, misalign_exc and timeout_exc are single-cycle pulses, registered.

Decomposition:
- Shared package (cpu_pkg): size encodings SZ_BYTE/SZ_HALF/SZ_WORD and state encodings for IDLE/BUS/RESP.
- One natural sub-module, mem_lane_align: combinational be/wdata generation and load extract/extend, reused by any future cache path.

Test Plan:
- Non-memory pass-through: ex_valid=1, alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5; stall never 1.
- Signed byte load: addr=0x103, size=byte, unsigned=0; ack after 2 cycles with rdata=0x80AA_BBCC -> dmem_addr=0x100, be=0000 (read), wb_data=0xFFFF_FF80, wb_reg_write=1; stall high from accept+1 until the RESP cycle.
- Half store: addr=0x202, data=0x0000_BEEF -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF; retire pulse with wb_reg_write=0.
- Misaligned word load: addr=0x301 -> no dmem_req; misalign_exc pulse; wb_reg_write=0.
- Timeout: TIMEOUT=15, ack withheld -> dmem_req high exactly 15 cycles, then timeout_exc pulse, state IDLE; a late ack is ignored.
- Reset mid-BUS: RST low two cycles into BUS -> dmem_req and stall 0 immediately (async); after release, a new load completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU data-memory path.
//   SZ_*      : access size encodings carried on ex_size (2'b11 is treated as a word)
//   state_e   : mem_access_unit control states
//   is_misaligned() : alignment rule shared by every memory access path
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for a 32-bit little-endian data bus.
//   Store side: st_addr_lo/st_size/st_data -> st_be (byte enables), st_wdata (lane-replicated data)
//   Load side : ld_addr_lo/ld_size/ld_unsigned/ld_word -> ld_data (lane extracted, sign/zero extended)
module mem_lane_align
  import cpu_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be    = '0;
    st_wdata = '0;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = '1;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    // Move the addressed lane down to bit 0 before extending.
    ld_shifted = ld_word >> {ld_addr_lo, 3'b000};
    ld_data    = '0;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: byte/half/word loads and stores over a req/ack bus,
// plus one-cycle pass-through of non-memory ALU results to write-back.
//   CLK, RST (async active-low)
//   ex_*       : execute-stage record, accepted only while stall=0
//   stall      : unit busy (BUS or RESP)
//   dmem_*     : registered bus request, held until ack or TIMEOUT cycles
//   wb_*       : registered one-cycle write-back record
//   misalign_exc, timeout_exc : one-cycle exception pulses
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_exc,
  output logic        timeout_exc
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [1:0]  rq_addr_lo_q, rq_addr_lo_d;
  logic [1:0]  rq_size_q, rq_size_d;
  logic        rq_unsigned_q, rq_unsigned_d;
  logic [4:0]  rq_rd_q, rq_rd_d;
  logic        rq_reg_write_q, rq_reg_write_d;
  logic        rq_load_q, rq_load_d;
  logic [31:0] rdata_q, rdata_d;

  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ld_data;

  mem_lane_align u_lane (
    .st_addr_lo  (alu_result[1:0]),
    .st_size     (ex_size),
    .st_data     (ex_store_data),
    .st_be       (lane_be),
    .st_wdata    (lane_wdata),
    .ld_addr_lo  (rq_addr_lo_q),
    .ld_size     (rq_size_q),
    .ld_unsigned (rq_unsigned_q),
    .ld_word     (rdata_q),
    .ld_data     (lane_ld_data)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rq_addr_lo_d   = rq_addr_lo_q;
    rq_size_d      = rq_size_q;
    rq_unsigned_d  = rq_unsigned_q;
    rq_rd_d        = rq_rd_q;
    rq_reg_write_d = rq_reg_write_q;
    rq_load_d      = rq_load_q;
    rdata_d        = rdata_q;
    dmem_req_d     = dmem_req_q;
    dmem_we_d      = dmem_we_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    dmem_be_d      = dmem_be_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_rd_d        = '0;
    wb_data_d      = '0;
    misalign_d     = 1'b0;
    timeout_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (ex_mem_read || ex_mem_write) begin
            if (is_misaligned(ex_size, alu_result[1:0])) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = ex_rd;
              misalign_d = 1'b1;
            end else begin
              rq_addr_lo_d   = alu_result[1:0];
              rq_size_d      = ex_size;
              rq_unsigned_d  = ex_unsigned;
              rq_rd_d        = ex_rd;
              rq_reg_write_d = ex_reg_write;
              rq_load_d      = ex_mem_read;
              dmem_req_d     = 1'b1;
              dmem_we_d      = ex_mem_write;
              dmem_addr_d    = {alu_result[31:2], 2'b00};
              // Reads carry no byte enables or data; lane selection happens on return.
              dmem_be_d      = ex_mem_write ? lane_be : 4'b0000;
              dmem_wdata_d   = ex_mem_write ? lane_wdata : '0;
              cnt_d          = '0;
              state_d        = ST_BUS;
            end
          end else begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = ex_reg_write;
            wb_rd_d        = ex_rd;
            wb_data_d      = alu_result;
          end
        end
      end

      ST_BUS: begin
        // Ack is tested first so it wins over a timeout in the same cycle.
        if (dmem_ack) begin
          rdata_d      = dmem_rdata;
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_addr_d  = '0;
          dmem_wdata_d = '0;
          dmem_be_d    = '0;
          cnt_d        = '0;
          state_d      = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_addr_d  = '0;
          dmem_wdata_d = '0;
          dmem_be_d    = '0;
          cnt_d        = '0;
          wb_valid_d   = 1'b1;
          wb_rd_d      = rq_rd_q;
          timeout_d    = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RESP: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rq_rd_q;
        if (rq_load_q) begin
          wb_reg_write_d = rq_reg_write_q;
          wb_data_d      = lane_ld_data;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      rq_addr_lo_q   <= '0;
      rq_size_q      <= '0;
      rq_unsigned_q  <= 1'b0;
      rq_rd_q        <= '0;
      rq_reg_write_q <= 1'b0;
      rq_load_q      <= 1'b0;
      rdata_q        <= '0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      dmem_be_q      <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      misalign_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rq_addr_lo_q   <= rq_addr_lo_d;
      rq_size_q      <= rq_size_d;
      rq_unsigned_q  <= rq_unsigned_d;
      rq_rd_q        <= rq_rd_d;
      rq_reg_write_q <= rq_reg_write_d;
      rq_load_q      <= rq_load_d;
      rdata_q        <= rdata_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
      dmem_be_q      <= dmem_be_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      misalign_q     <= misalign_d;
      timeout_q      <= timeout_d;
    end
  end

  assign stall        = (state_q != ST_IDLE);
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_be      = dmem_be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_exc = misalign_q;
  assign timeout_exc  = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned TO = 15;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned, ex_reg_write;
  logic [1:0]  ex_size;
  logic [31:0] alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_reg_write, misalign_exc, timeout_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .alu_result(alu_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_exc(misalign_exc), .timeout_exc(timeout_exc)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs for the current cycle, set by the stimulus timeline.
  bit          chk_en;
  bit          exp_stall, exp_req, exp_we, exp_wb_valid, exp_wb_rw, exp_chk_data;
  bit          exp_misalign, exp_timeout;
  logic [31:0] exp_addr, exp_wdata, exp_wb_data;
  logic [3:0]  exp_be;
  logic [4:0]  exp_wb_rd;

  // Observations used by the literal pins.
  int          n_req_cycles = 0;
  int          n_misalign = 0;
  int          n_timeout = 0;
  logic [31:0] seen_addr, seen_wdata, seen_wb_data;
  logic [3:0]  seen_be;
  logic        seen_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic bit misaligned_f(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [31:0] a);
    int lane = int'(a % 4);
    if (sz == 2'b00) return 4'(1 << lane);
    if (sz == 2'b01) return (lane >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return (d % 256) * 32'h0101_0101;
    if (sz == 2'b01) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] load_f(input logic [1:0] sz, input bit uns,
                                         input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int lane = int'(a % 4);
    if (sz == 2'b00) begin
      v = (w >> (8 * lane)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'b01) begin
      v = (w >> (8 * lane)) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return w;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("dmem_req", 32'(dmem_req), 32'(exp_req));
      if (exp_req) begin
        check("dmem_we", 32'(dmem_we), 32'(exp_we));
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_be", 32'(dmem_be), 32'(exp_be));
        check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      check("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
      if (exp_wb_valid) begin
        check("wb_reg_write", 32'(wb_reg_write), 32'(exp_wb_rw));
        if (exp_chk_data) begin
          check("wb_rd", 32'(wb_rd), 32'(exp_wb_rd));
          check("wb_data", wb_data, exp_wb_data);
        end
      end
      check("misalign_exc", 32'(misalign_exc), 32'(exp_misalign));
      check("timeout_exc", 32'(timeout_exc), 32'(exp_timeout));
    end
    if (dmem_req) begin
      n_req_cycles++;
      seen_addr  = dmem_addr;
      seen_be    = dmem_be;
      seen_wdata = dmem_wdata;
      seen_we    = dmem_we;
    end
    if (wb_valid) seen_wb_data = wb_data;
    if (misalign_exc) n_misalign++;
    if (timeout_exc) n_timeout++;
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_idle;
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_wb_valid = 0; exp_wb_rw = 0;
    exp_chk_data = 0; exp_misalign = 0; exp_timeout = 0;
    exp_addr = '0; exp_wdata = '0; exp_be = '0; exp_wb_data = '0; exp_wb_rd = '0;
  endtask

  // ack_at: BUS cycle (1-based) in which ack is returned; 0 = never.
  task automatic run_op(input bit is_rd, input bit is_wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                        input bit rw, input int ack_at, input logic [31:0] rdata, input bit late_ack);
    ex_valid = 1; ex_mem_read = is_rd; ex_mem_write = is_wr; ex_size = sz; ex_unsigned = uns;
    alu_result = addr; ex_store_data = sdata; ex_rd = rd; ex_reg_write = rw;
    tick;
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
    if (!(is_rd || is_wr)) begin
      exp_wb_valid = 1; exp_wb_rw = rw; exp_wb_rd = rd; exp_wb_data = addr; exp_chk_data = 1;
      tick;
      exp_idle;
      return;
    end
    if (misaligned_f(sz, addr)) begin
      exp_wb_valid = 1; exp_wb_rw = 0; exp_misalign = 1;
      tick;
      exp_idle;
      return;
    end
    exp_stall = 1; exp_req = 1; exp_we = is_wr;
    exp_addr  = addr - (addr % 4);
    exp_be    = is_wr ? be_f(sz, addr) : 4'b0000;
    exp_wdata = is_wr ? wdata_f(sz, sdata) : 32'h0;
    for (int k = 1; k <= int'(TO); k++) begin
      dmem_ack = (k == ack_at);
      dmem_rdata = rdata;
      tick;
      if (k == ack_at) begin
        dmem_ack = 0;
        exp_req = 0;
        tick;
        exp_stall = 0; exp_wb_valid = 1; exp_wb_rd = rd; exp_chk_data = 1;
        exp_wb_rw   = is_rd && rw;
        exp_wb_data = is_rd ? load_f(sz, uns, addr, rdata) : 32'h0;
        tick;
        exp_idle;
        return;
      end
    end
    dmem_ack = late_ack;
    exp_stall = 0; exp_req = 0; exp_timeout = 1; exp_wb_valid = 1; exp_wb_rw = 0;
    tick;
    dmem_ack = 0;
    exp_idle;
    tick;
  endtask

  initial begin
    int r0, m0, t0;
    RST = 0; chk_en = 0;
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_size = 0; ex_unsigned = 0;
    alu_result = 0; ex_store_data = 0; ex_rd = 0; ex_reg_write = 0;
    dmem_ack = 0; dmem_rdata = 0;
    exp_idle;
    #2 chk_en = 1;
    repeat (2) @(posedge CLK);
    #1 RST = 1;
    tick;

    // non-memory pass-through
    run_op(0, 0, 2'b10, 0, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 32'h0, 0);
    check("pin_passthru_data", seen_wb_data, 32'h0000_1234);
    run_op(0, 0, 2'b00, 0, 32'hDEAD_0001, 32'h0, 5'd9, 0, 0, 32'h0, 0);

    // signed byte load, ack in third BUS cycle
    run_op(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 5'd7, 1, 3, 32'h80AA_BBCC, 0);
    check("pin_sbyte_addr", seen_addr, 32'h0000_0100);
    check("pin_sbyte_be", 32'(seen_be), 32'h0);
    check("pin_sbyte_data", seen_wb_data, 32'hFFFF_FF80);

    // half store at upper half
    run_op(0, 1, 2'b01, 0, 32'h0000_0202, 32'h0000_BEEF, 5'd3, 1, 2, 32'h0, 0);
    check("pin_hstore_we", 32'(seen_we), 32'h1);
    check("pin_hstore_be", 32'(seen_be), 32'hC);
    check("pin_hstore_wdata", seen_wdata, 32'hBEEF_BEEF);

    // misaligned word load: no bus cycle
    r0 = n_req_cycles; m0 = n_misalign;
    run_op(1, 0, 2'b10, 0, 32'h0000_0301, 32'h0, 5'd4, 1, 1, 32'h0, 0);
    check("pin_misalign_noreq", 32'(n_req_cycles - r0), 32'h0);
    check("pin_misalign_pulse", 32'(n_misalign - m0), 32'h1);

    // timeout with a late ack afterwards
    r0 = n_req_cycles; t0 = n_timeout;
    run_op(1, 0, 2'b10, 0, 32'h0000_0400, 32'h0, 5'd6, 1, 0, 32'h1234_5678, 1);
    check("pin_timeout_req_cycles", 32'(n_req_cycles - r0), 32'd15);
    check("pin_timeout_pulse", 32'(n_timeout - t0), 32'h1);

    // ack in the same cycle the counter reaches TIMEOUT: ack wins
    t0 = n_timeout;
    run_op(1, 0, 2'b10, 0, 32'h0000_0480, 32'h0, 5'd8, 1, int'(TO), 32'hCAFE_F00D, 0);
    check("pin_ack_wins_no_timeout", 32'(n_timeout - t0), 32'h0);
    check("pin_ack_wins_data", seen_wb_data, 32'hCAFE_F00D);

    // lane / extension variety, best-case ack
    run_op(1, 0, 2'b01, 1, 32'h0000_0502, 32'h0, 5'd10, 1, 1, 32'h8001_1234, 0);
    check("pin_uhalf_data", seen_wb_data, 32'h0000_8001);
    run_op(1, 0, 2'b01, 0, 32'h0000_0500, 32'h0, 5'd11, 1, 1, 32'h0000_F00D, 0);
    check("pin_shalf_data", seen_wb_data, 32'hFFFF_F00D);
    run_op(1, 0, 2'b00, 1, 32'h0000_0601, 32'h0, 5'd12, 1, 2, 32'h1122_3344, 0);
    check("pin_ubyte_data", seen_wb_data, 32'h0000_0033);
    run_op(0, 1, 2'b00, 0, 32'h0000_0703, 32'h1234_5678, 5'd13, 0, 1, 32'h0, 0);
    check("pin_bstore_be", 32'(seen_be), 32'h8);
    check("pin_bstore_wdata", seen_wdata, 32'h7878_7878);
    run_op(1, 0, 2'b11, 0, 32'h0000_0800, 32'h0, 5'd14, 1, 1, 32'h8765_4321, 0);
    run_op(0, 1, 2'b10, 0, 32'h0000_0804, 32'hA5A5_0F0F, 5'd15, 1, 1, 32'h0, 0);
    run_op(1, 0, 2'b01, 0, 32'h0000_0901, 32'h0, 5'd16, 1, 1, 32'h0, 0);
    run_op(1, 0, 2'b00, 0, 32'h0000_0902, 32'h0, 5'd0, 0, 1, 32'h0000_7F00, 0);

    // reset two cycles into BUS
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b10; alu_result = 32'h0000_0A00; ex_rd = 5'd20;
    ex_reg_write = 1;
    tick;
    ex_valid = 0; ex_mem_read = 0;
    exp_stall = 1; exp_req = 1; exp_we = 0; exp_addr = 32'h0000_0A00; exp_be = 0; exp_wdata = 0;
    tick;
    tick;
    RST = 0;
    exp_idle;
    #1;
    check("async_rst_stall", 32'(stall), 32'h0);
    check("async_rst_req", 32'(dmem_req), 32'h0);
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    tick;
    tick;
    RST = 1;
    tick;
    dmem_ack = 0;
    run_op(1, 0, 2'b10, 0, 32'h0000_0B00, 32'h0, 5'd21, 1, 2, 32'h0BAD_BEEF, 0);
    check("pin_after_reset_data", seen_wb_data, 32'h0BAD_BEEF);
    tick;

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
